// File: rtl/karatsuba_seq.sv
// Sequential 8x8 unsigned Karatsuba multiplier sharing one 5x5-bit product ROM over three lookups.
// Optional self-check against a behavioral multiply is enabled by defining KARATSUBA_SEQ_CHECK_EN.
module karatsuba_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  X,
  input  logic [7:0]  Y,
  output logic [9:0]  rom_addr,
  input  logic [9:0]  rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] P,
  output logic        chk_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MUL_A = 3'd1;
  localparam logic [2:0] ST_MUL_B = 3'd2;
  localparam logic [2:0] ST_MUL_C = 3'd3;
  localparam logic [2:0] ST_COMB  = 3'd4;
  localparam logic [2:0] ST_OUT   = 3'd5;

  logic [2:0]  state_reg;
  logic [7:0]  x_reg;
  logic [7:0]  y_reg;
  logic [9:0]  a_reg;
  logic [9:0]  b_reg;
  logic [9:0]  c_reg;
  logic [15:0] p_reg;

  logic [4:0]  x_sum;
  logic [4:0]  y_sum;
  logic [9:0]  m;
  logic [15:0] p_next;

  // Half sums keep their carry so the middle lookup is a true 5x5 product.
  assign x_sum = {1'b0, x_reg[7:4]} + {1'b0, x_reg[3:0]};
  assign y_sum = {1'b0, y_reg[7:4]} + {1'b0, y_reg[3:0]};

  assign m      = c_reg - a_reg - b_reg;
  assign p_next = {b_reg[7:0], 8'h00} + {2'b00, m, 4'h0} + {6'b0, a_reg};

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_OUT);
  assign P         = p_reg;

  always_comb begin
    rom_addr = 10'd0;
    case (state_reg)
      ST_MUL_A: rom_addr = {1'b0, x_reg[3:0], 1'b0, y_reg[3:0]};
      ST_MUL_B: rom_addr = {1'b0, x_reg[7:4], 1'b0, y_reg[7:4]};
      ST_MUL_C: rom_addr = {x_sum, y_sum};
      default:  rom_addr = 10'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      x_reg     <= 8'd0;
      y_reg     <= 8'd0;
      a_reg     <= 10'd0;
      b_reg     <= 10'd0;
      c_reg     <= 10'd0;
      p_reg     <= 16'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg     <= X;
            y_reg     <= Y;
            state_reg <= ST_MUL_A;
          end
        end
        ST_MUL_A: begin
          a_reg     <= rom_data;
          state_reg <= ST_MUL_B;
        end
        ST_MUL_B: begin
          b_reg     <= rom_data;
          state_reg <= ST_MUL_C;
        end
        ST_MUL_C: begin
          c_reg     <= rom_data;
          state_reg <= ST_COMB;
        end
        ST_COMB: begin
          p_reg     <= p_next;
          state_reg <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

`ifdef KARATSUBA_SEQ_CHECK_EN
  logic        chk_err_reg;
  logic [15:0] ref_p;

  assign ref_p   = {8'h00, x_reg} * {8'h00, y_reg};
  assign chk_err = chk_err_reg;

  // Sticky: once a bad combine is seen it stays flagged until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_reg <= 1'b0;
    end else if (state_reg == ST_COMB && p_next != ref_p) begin
      chk_err_reg <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule
